// File: rtl/dds_frame_parser.sv
// UART command-frame decoder: AA 55 CMD LEN PAYLOAD CHK CE.
// Drives DDS trigger settings, forwards AD9910 register writes and answers with ACK/NAK.
module dds_frame_parser #(
    parameter logic [7:0]  HEAD_FREAME_1 = 8'hAA,
    parameter logic [7:0]  HEAD_FREAME_2 = 8'h55,
    parameter logic [7:0]  END_FREAME    = 8'hCE,
    parameter int          MAX_LEN       = 9,
    parameter int          TIMEOUT_CYC   = 500000,
    parameter logic [15:0] TRIG_DEFAULT  = 16'd2000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] triger_pulse,
    output logic        pulse_position,
    output logic [7:0]  reg_addr,
    output logic [63:0] reg_data,
    output logic [3:0]  reg_len,
    output logic        reg_valid,
    input  logic        reg_ready,
    output logic [7:0]  ack_data,
    output logic        ack_valid,
    output logic        frame_err
);

    localparam int             CNT_W        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]     MAX_LEN_B    = 8'(MAX_LEN);
    localparam logic [7:0]     ACK_BYTE     = 8'h06;
    localparam logic [7:0]     NAK_BYTE     = 8'h15;

    typedef enum logic [2:0] {
        IDLE, HEAD2, CMD, LEN, PAYLOAD, CHK, TAIL, EXEC
    } state_t;

    state_t           state;
    logic [3:0]       idx;
    logic [CNT_W-1:0] tmo_cnt;

    logic [7:0]  cmd;
    logic [7:0]  len;
    logic [7:0]  sum;
    logic        chk_bad;
    logic [7:0]  payload [MAX_LEN];
    logic [63:0] reg_data_nxt;
    logic [3:0]  data_cnt;

    wire in_frame = (state != IDLE) && (state != EXEC);
    wire tmo_hit  = in_frame && !rx_valid && (tmo_cnt == TIMEOUT_LAST);

    assign data_cnt = len[3:0] - 4'd1;

    // Register data is left-aligned: payload[1] lands in [63:56], unused bytes are zero.
    always_comb begin
        reg_data_nxt = '0;
        for (int i = 0; i < 8 && i < MAX_LEN - 1; i++) begin
            if (4'(i) < data_cnt)
                reg_data_nxt[63 - 8*i -: 8] = payload[i + 1];
        end
    end

    // Frame contents and running checksum; only meaningful while a frame is in flight.
    always_ff @(posedge sys_clk) begin
        if (rx_valid) begin
            case (state)
                CMD: begin
                    cmd <= rx_data;
                    sum <= rx_data;
                end
                LEN: begin
                    len <= rx_data;
                    sum <= sum + rx_data;
                end
                PAYLOAD: begin
                    payload[idx] <= rx_data;
                    sum          <= sum + rx_data;
                end
                CHK:     chk_bad <= (rx_data != sum);
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state          <= IDLE;
            idx            <= '0;
            tmo_cnt        <= '0;
            triger_pulse   <= TRIG_DEFAULT;
            pulse_position <= 1'b0;
            reg_addr       <= '0;
            reg_data       <= '0;
            reg_len        <= '0;
            reg_valid      <= 1'b0;
            ack_data       <= '0;
            ack_valid      <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            ack_valid <= 1'b0;
            frame_err <= 1'b0;

            if (!in_frame || rx_valid)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;

            if (tmo_hit) begin
                frame_err <= 1'b1;
                state     <= IDLE;
            end else begin
                case (state)
                    IDLE: if (rx_valid && rx_data == HEAD_FREAME_1) state <= HEAD2;
                    HEAD2: begin
                        if (rx_valid) begin
                            if (rx_data == HEAD_FREAME_2)
                                state <= CMD;
                            else if (rx_data != HEAD_FREAME_1)
                                state <= IDLE;
                        end
                    end
                    CMD: if (rx_valid) state <= LEN;
                    LEN: begin
                        if (rx_valid) begin
                            idx <= '0;
                            if (rx_data > MAX_LEN_B) begin
                                ack_data  <= NAK_BYTE;
                                ack_valid <= 1'b1;
                                frame_err <= 1'b1;
                                state     <= IDLE;
                            end else if (rx_data == 8'd0) begin
                                state <= CHK;
                            end else begin
                                state <= PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (rx_valid) begin
                            idx <= idx + 4'd1;
                            if (idx == data_cnt)
                                state <= CHK;
                        end
                    end
                    CHK: if (rx_valid) state <= TAIL;
                    TAIL: begin
                        if (rx_valid) begin
                            state <= IDLE;
                            if (rx_data != END_FREAME || chk_bad) begin
                                ack_data  <= NAK_BYTE;
                                ack_valid <= 1'b1;
                                frame_err <= 1'b1;
                            end else begin
                                case (cmd)
                                    8'h01: begin
                                        if (len == 8'd2) begin
                                            triger_pulse <= {payload[0], payload[1]};
                                            ack_data     <= ACK_BYTE;
                                            ack_valid    <= 1'b1;
                                        end else begin
                                            ack_data  <= NAK_BYTE;
                                            ack_valid <= 1'b1;
                                            frame_err <= 1'b1;
                                        end
                                    end
                                    8'h02: begin
                                        if (len == 8'd1) begin
                                            pulse_position <= payload[0][0];
                                            ack_data       <= ACK_BYTE;
                                            ack_valid      <= 1'b1;
                                        end else begin
                                            ack_data  <= NAK_BYTE;
                                            ack_valid <= 1'b1;
                                            frame_err <= 1'b1;
                                        end
                                    end
                                    8'h10: begin
                                        if (len >= 8'd2) begin
                                            reg_addr  <= payload[0];
                                            reg_data  <= reg_data_nxt;
                                            reg_len   <= data_cnt;
                                            reg_valid <= 1'b1;
                                            state     <= EXEC;
                                        end else begin
                                            ack_data  <= NAK_BYTE;
                                            ack_valid <= 1'b1;
                                            frame_err <= 1'b1;
                                        end
                                    end
                                    default: begin
                                        ack_data  <= NAK_BYTE;
                                        ack_valid <= 1'b1;
                                        frame_err <= 1'b1;
                                    end
                                endcase
                            end
                        end
                    end
                    EXEC: begin
                        // Bytes arriving while the SPI engine is busy are ignored.
                        if (reg_valid && reg_ready) begin
                            reg_valid <= 1'b0;
                            ack_data  <= ACK_BYTE;
                            ack_valid <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dds_frame_parser.sv
// Directed bench for dds_frame_parser; ACK/NAK/abort events are checked against a queue
// of expected events filled as each frame is sent.
module tb_dds_frame_parser;

    localparam int TMO = 100;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        reg_ready = 1'b0;
    logic [15:0] triger_pulse;
    logic        pulse_position;
    logic [7:0]  reg_addr;
    logic [63:0] reg_data;
    logic [3:0]  reg_len;
    logic        reg_valid;
    logic [7:0]  ack_data;
    logic        ack_valid;
    logic        frame_err;

    dds_frame_parser #(.TIMEOUT_CYC(TMO)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .triger_pulse(triger_pulse), .pulse_position(pulse_position),
        .reg_addr(reg_addr), .reg_data(reg_data), .reg_len(reg_len),
        .reg_valid(reg_valid), .reg_ready(reg_ready),
        .ack_data(ack_data), .ack_valid(ack_valid), .frame_err(frame_err)
    );

    always #10 sys_clk = ~sys_clk;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       e;
    } ev_t;

    localparam ev_t EV_ACK = '{v: 1'b1, d: 8'h06, e: 1'b0};
    localparam ev_t EV_NAK = '{v: 1'b1, d: 8'h15, e: 1'b1};
    localparam ev_t EV_TMO = '{v: 1'b0, d: 8'h00, e: 1'b1};

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge sys_clk) begin : monitor
        ev_t e;
        if (sys_rst && (ack_valid || frame_err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_event: observed ack_valid=%0b ack_data=%0h frame_err=%0b expected no event",
                       ack_valid, ack_data, frame_err);
            end else begin
                e = exp_q.pop_front();
                chk("ack_valid", 64'(ack_valid), 64'(e.v));
                if (e.v) chk("ack_data", 64'(ack_data), 64'(e.d));
                chk("frame_err", 64'(frame_err), 64'(e.e));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge sys_clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge sys_clk);
        rx_valid = 1'b0;
    endtask

    // Payload is right-aligned in pl: the first payload byte is the most significant of n.
    task automatic send_frame(input logic [7:0] cmd, input int n, input logic [71:0] pl,
                              input logic [7:0] chk_xor, input logic [7:0] tail);
        logic [7:0] s;
        s = cmd + 8'(n);
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(cmd);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            s = s + pl[8*(n-1-i) +: 8];
            send_byte(pl[8*(n-1-i) +: 8]);
        end
        send_byte(s ^ chk_xor);
        send_byte(tail);
    endtask

    task automatic drain(input string tag);
        repeat (2) @(negedge sys_clk);
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_triger"}, 64'(triger_pulse), 64'd2000);
        chk({tag, "_pos"}, 64'(pulse_position), 64'd0);
        chk({tag, "_addr"}, 64'(reg_addr), 64'd0);
        chk({tag, "_data"}, reg_data, 64'd0);
        chk({tag, "_len"}, 64'(reg_len), 64'd0);
        chk({tag, "_rvalid"}, 64'(reg_valid), 64'd0);
        chk({tag, "_ackv"}, 64'(ack_valid), 64'd0);
        chk({tag, "_err"}, 64'(frame_err), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi;
        int w;

        repeat (3) @(negedge sys_clk);
        check_reset_values("reset");
        chk("reset_ackd", 64'(ack_data), 64'd0);
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);

        // trigger width write
        exp_q.push_back(EV_ACK);
        send_frame(8'h01, 2, 72'h03E8, 8'h00, 8'hCE);
        chk("trig_03e8", 64'(triger_pulse), 64'h03E8);
        drain("drain_trig");

        // pulse position, then a bad-checksum frame that would clear it
        exp_q.push_back(EV_ACK);
        send_frame(8'h02, 1, 72'h01, 8'h00, 8'hCE);
        chk("pos_set", 64'(pulse_position), 64'd1);
        exp_q.push_back(EV_NAK);
        send_frame(8'h02, 1, 72'h00, 8'h01, 8'hCE);
        chk("pos_kept_badchk", 64'(pulse_position), 64'd1);
        drain("drain_pos");

        // header resync on AA AA 55
        exp_q.push_back(EV_ACK);
        send_byte(8'hAA);
        send_frame(8'h01, 2, 72'h0064, 8'h00, 8'hCE);
        chk("trig_resync", 64'(triger_pulse), 64'd100);
        drain("drain_resync");

        // length above MAX_LEN rejected at the LEN byte
        exp_q.push_back(EV_NAK);
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h0A);
        drain("drain_len10");

        // wrong length, unknown command, bad tail, zero-length cmd 02
        exp_q.push_back(EV_NAK);
        send_frame(8'h01, 1, 72'h12, 8'h00, 8'hCE);
        exp_q.push_back(EV_NAK);
        send_frame(8'h33, 1, 72'h01, 8'h00, 8'hCE);
        exp_q.push_back(EV_NAK);
        send_frame(8'h01, 2, 72'h1234, 8'h00, 8'hCD);
        exp_q.push_back(EV_NAK);
        send_frame(8'h02, 0, 72'h0, 8'h00, 8'hCE);
        chk("trig_kept_rejects", 64'(triger_pulse), 64'd100);
        chk("pos_kept_rejects", 64'(pulse_position), 64'd1);
        drain("drain_rejects");

        // register write held off by reg_ready for 20 cycles
        reg_ready = 1'b0;
        exp_q.push_back(EV_ACK);
        send_frame(8'h10, 5, 72'h0111223344, 8'h00, 8'hCE);
        chk("reg_valid_rise", 64'(reg_valid), 64'd1);
        chk("reg_addr", 64'(reg_addr), 64'h01);
        chk("reg_data_hi", 64'(reg_data[63:32]), 64'h11223344);
        chk("reg_len4", 64'(reg_len), 64'd4);
        hi = 1;
        repeat (19) begin
            @(negedge sys_clk);
            if (reg_valid) hi++;
        end
        chk("reg_valid_20cyc", 64'(hi), 64'd20);
        send_byte(8'hAA);
        chk("reg_valid_hold_rx", 64'(reg_valid), 64'd1);
        reg_ready = 1'b1;
        @(negedge sys_clk);
        reg_ready = 1'b0;
        chk("reg_valid_drop", 64'(reg_valid), 64'd0);
        drain("drain_exec");

        // maximum payload: address + 8 data bytes
        reg_ready = 1'b1;
        exp_q.push_back(EV_ACK);
        send_frame(8'h10, 9, 72'h80_0102030405060708, 8'h00, 8'hCE);
        chk("reg9_valid", 64'(reg_valid), 64'd1);
        chk("reg9_addr", 64'(reg_addr), 64'h80);
        chk("reg9_data", reg_data, 64'h0102030405060708);
        chk("reg9_len", 64'(reg_len), 64'd8);
        drain("drain_reg9");
        reg_ready = 1'b0;

        // mid-frame silence aborts with frame_err only
        exp_q.push_back(EV_TMO);
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h01);
        w = 0;
        while (exp_q.size() != 0 && w < TMO + 20) begin
            @(negedge sys_clk);
            w++;
        end
        chk("tmo_fired", 64'(exp_q.size()), 64'd0);
        chk("tmo_latency", 64'(w >= TMO - 5 && w <= TMO + 5), 64'd1);
        exp_q.push_back(EV_ACK);
        send_frame(8'h01, 2, 72'h0BB8, 8'h00, 8'hCE);
        chk("trig_after_tmo", 64'(triger_pulse), 64'h0BB8);
        drain("drain_tmo");

        // reset in the middle of a payload
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h10);
        send_byte(8'h05);
        send_byte(8'h01);
        send_byte(8'h11);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check_reset_values("midrst");
        sys_rst = 1'b1;
        @(negedge sys_clk);
        exp_q.push_back(EV_ACK);
        send_frame(8'h01, 2, 72'h1234, 8'h00, 8'hCE);
        chk("trig_after_rst", 64'(triger_pulse), 64'h1234);
        drain("drain_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
